aim_layer_sched: RTL and testbench
==================================

Name: aim_layer_sched

Overview:
- Sequences one fully connected ternary layer through a single shared 8-input AIM neuron core.
- Latches an 8-element activation vector, then for each output neuron fetches that neuron's ternary weight row from a synchronous weight ROM.
- Starts the core for each row, collects the 12-bit result and streams it out with a valid/ready handshake.
- Rows whose weights are all zero bypass the core, in keeping with the zero-skip character of the neuron datapath.

Parameters:
- NUM_NEURONS, 16, number of output neurons (weight rows) in the layer; legal range 1..256.
- IDX_W, $clog2(NUM_NEURONS) with a minimum of 1, width of the row index and ROM address.
- CORE_TIMEOUT, 64, maximum cycles to wait for core_done before the row is aborted.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle layer start request.
- act_in  in  72  eight signed 9-bit activations; A1 occupies bits [8:0], A8 occupies bits [71:63].
- busy  out  1  high from the accepted start until the layer completes.
- layer_done  out  1  one-cycle pulse after the last result has been accepted.
- err  out  1  sticky core-timeout flag; cleared by reset or by an accepted start.
- wrom_addr  out  IDX_W  weight ROM row address.
- wrom_rd  out  1  ROM read strobe; data is valid exactly 1 cycle later.
- wrom_data  in  16  eight signed 2-bit weights; W1 occupies bits [1:0].
- core_start  out  1  one-cycle core start pulse.
- core_act  out  72  latched activation vector, held constant while busy.
- core_wt  out  16  current weight row, held from core_start until core_done.
- core_done  in  1  one-cycle pulse from the core; qualifies core_result.
- core_result  in  12  signed neuron sum.
- res_valid  out  1  output result valid.
- res_ready  in  1  downstream ready.
- res_data  out  12  signed result.
- res_idx  out  IDX_W  row index of res_data.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE.
  - Outputs busy, layer_done, err, wrom_rd, core_start and res_valid are 0.
  - Data outputs wrom_addr, core_act, core_wt, res_data and res_idx are all 0.
- Reset mid-layer aborts the layer immediately; nothing is emitted afterwards.
- IDLE: on start=1:
  - latch act_in into core_act;
  - set row=0 and clear err;
  - set busy=1 and go to FETCH.
- start is ignored in every state other than IDLE.
- FETCH: drive wrom_rd=1 and wrom_addr=row for 1 cycle, then go to WAIT_MEM.
- WAIT_MEM: capture wrom_data into core_wt.
  - If wrom_data==0: res_data=0 and go to EMIT (core skipped).
  - Otherwise go to ISSUE.
- ISSUE: drive core_start=1 for 1 cycle, clear the timeout counter, then go to WAIT_CORE.
- WAIT_CORE: increment the counter every cycle.
  - On core_done: capture core_result into res_data and go to EMIT.
  - If the counter reaches CORE_TIMEOUT without core_done: err=1, res_data=0, go to EMIT.
  - If core_done and expiry coincide, core_done wins and err is not set.
  - A core_done arriving in any other state is ignored.
- EMIT: res_valid=1 and res_idx=row.
  - res_data and res_idx stay stable until res_valid && res_ready.
  - res_valid never drops without a handshake.
  - On handshake with row==NUM_NEURONS-1: layer_done=1 for 1 cycle, busy=0, go to IDLE.
  - On handshake otherwise: row++ and go to FETCH.
- Weight code 2'b10 (-2) is forwarded to the core untouched; it is not interpreted here.
- Latency for a nonzero row, start to first res_valid: 4 cycles plus the core latency.
- Latency for an all-zero row: 3 cycles.
- Row-to-row overhead after a handshake: 1 cycle.

Optional Feature:
- Macro: AIM_SCHED_RELU_EN.
- Defined: res_data is clamped to 0 whenever the captured value is negative (bit 11 set); positive values pass unchanged.
- Undefined: res_data carries the signed core_result exactly.
- Timeout and skip results are 0 in both builds.

Decomposition:
- Package aim_pkg holds:
  - ACT_W=9, WT_W=2, RES_W=12 and N_IN=8;
  - the state enum IDLE, FETCH, WAIT_MEM, ISSUE, WAIT_CORE, EMIT;
  - the packed types act_vec_t (72 bits) and wt_row_t (16 bits).
- One sub-module, aim_sched_timeout: a loadable down-counter with an expire output, instantiated once.

Test Plan:
- NUM_NEURONS=4; act all 9'd1; rows 16'h5555 (all +1), 16'hFFFF (all -1), 0, 16'h0001; core model returns the signed sum after 10 cycles -> res sequence (idx,data) = (0,8), (1,-8), (2,0 with core_start never pulsed), (3,1); single layer_done pulse; err=0.
- Backpressure: hold res_ready=0 for 5 cycles on row 1 -> res_valid stays high, res_data=-8 and res_idx=1 stable, no wrom_rd issued until the handshake.
- Timeout: core never asserts done, CORE_TIMEOUT=64 -> res_data=0 emitted 64 cycles after core_start; err=1 until the next start; the layer still finishes.
- start pulsed during WAIT_CORE and pulsed simultaneously with reset -> start is ignored; after reset all outputs are 0 and state is IDLE.
- rst_n=0 while in EMIT on row 2 -> res_valid=0 on the next cycle; no further results and no layer_done.
- With AIM_SCHED_RELU_EN defined, row 16'hFFFF and act 1 -> res_data=0 (undefined build: -8); row 16'h5555 -> 8 in both builds.

Source files
------------

// File: rtl/aim_layer_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aim_pkg
// Purpose  : Shared widths, FSM state encoding and packed vector types for
//            the AIM ternary layer scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package aim_pkg;

  localparam int ACT_W = 9;
  localparam int WT_W  = 2;
  localparam int RES_W = 12;
  localparam int N_IN  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_MEM  = 3'd2,
    ISSUE     = 3'd3,
    WAIT_CORE = 3'd4,
    EMIT      = 3'd5
  } state_t;

  // Element [0] sits in the least significant bits (A1 / W1).
  typedef logic [N_IN-1:0][ACT_W-1:0] act_vec_t;
  typedef logic [N_IN-1:0][WT_W-1:0]  wt_row_t;

  // Clamp a negative signed result to zero; positive values pass unchanged.
  function automatic logic [RES_W-1:0] relu_clamp(input logic [RES_W-1:0] v);
    return v[RES_W-1] ? '0 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aim_sched_timeout.sv
`default_nettype none
// ============================================================================
// Module   : aim_sched_timeout
// Purpose  : Loadable down-counter guarding the wait for the neuron core.
//            Loaded on the cycle the core is issued; o_expire rises
//            CORE_TIMEOUT-1 cycles after the core_start cycle, so the row is
//            emitted CORE_TIMEOUT cycles after core_start.
// Revision : 1.0 - initial release
// ============================================================================
module aim_sched_timeout #(
  parameter int CORE_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_expire
);

  localparam int CNT_W = $clog2(CORE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CORE_TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Reload on issue, then count down to zero and hold there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/aim_layer_sched.sv
`default_nettype none
// ============================================================================
// Module   : aim_layer_sched
// Purpose  : Sequences one fully connected ternary layer through a shared
//            8-input AIM neuron core. Rows of all-zero weights skip the core.
//            Optional build macro AIM_SCHED_RELU_EN clamps negative core
//            results to zero.
// Revision : 1.0 - initial release
// ============================================================================
module aim_layer_sched
  import aim_pkg::*;
#(
  parameter int NUM_NEURONS  = 16,
  parameter int IDX_W        = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  parameter int CORE_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [71:0]      act_in,
  output logic             busy,
  output logic             layer_done,
  output logic             err,
  output logic [IDX_W-1:0] wrom_addr,
  output logic             wrom_rd,
  input  logic [15:0]      wrom_data,
  output logic             core_start,
  output logic [71:0]      core_act,
  output logic [15:0]      core_wt,
  input  logic             core_done,
  input  logic [11:0]      core_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [11:0]      res_data,
  output logic [IDX_W-1:0] res_idx
);

  state_t           r_state;
  logic [IDX_W-1:0] r_row;
  act_vec_t         r_act;
  wt_row_t          r_wt;
  logic             r_busy;
  logic             r_layer_done;
  logic             r_err;
  logic             r_rd;
  logic             r_core_start;
  logic             r_valid;
  logic [RES_W-1:0] r_res;

  logic             w_tmo_load;
  logic             w_expire;
  logic             w_last;
  logic [RES_W-1:0] w_core_val;

  // The watchdog is armed on the same edge that raises core_start.
  assign w_tmo_load = (r_state == WAIT_MEM) && (wrom_data != '0);
  assign w_last     = (r_row == IDX_W'(NUM_NEURONS - 1));

`ifdef AIM_SCHED_RELU_EN
  assign w_core_val = relu_clamp(core_result);
`else
  assign w_core_val = core_result;
`endif

  aim_sched_timeout #(
    .CORE_TIMEOUT (CORE_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_tmo_load),
    .o_expire (w_expire)
  );

  // Layer sequencer: fetch row, optionally run the core, emit, advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_row        <= '0;
      r_act        <= '0;
      r_wt         <= '0;
      r_busy       <= 1'b0;
      r_layer_done <= 1'b0;
      r_err        <= 1'b0;
      r_rd         <= 1'b0;
      r_core_start <= 1'b0;
      r_valid      <= 1'b0;
      r_res        <= '0;
    end else begin
      r_rd         <= 1'b0;
      r_core_start <= 1'b0;
      r_layer_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_act   <= act_in;
            r_row   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_rd    <= 1'b1;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          r_state <= WAIT_MEM;
        end
        WAIT_MEM: begin
          r_wt <= wrom_data;
          if (wrom_data == '0) begin
            r_res   <= '0;
            r_valid <= 1'b1;
            r_state <= EMIT;
          end else begin
            r_core_start <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= WAIT_CORE;
        end
        WAIT_CORE: begin
          // core_done has priority over a coincident expiry.
          if (core_done) begin
            r_res   <= w_core_val;
            r_valid <= 1'b1;
            r_state <= EMIT;
          end else if (w_expire) begin
            r_err   <= 1'b1;
            r_res   <= '0;
            r_valid <= 1'b1;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (r_valid && res_ready) begin
            r_valid <= 1'b0;
            if (w_last) begin
              r_layer_done <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= IDLE;
            end else begin
              r_row   <= r_row + IDX_W'(1);
              r_rd    <= 1'b1;
              r_state <= FETCH;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign layer_done = r_layer_done;
  assign err        = r_err;
  assign wrom_addr  = r_row;
  assign wrom_rd    = r_rd;
  assign core_start = r_core_start;
  assign core_act   = r_act;
  assign core_wt    = r_wt;
  assign res_valid  = r_valid;
  assign res_data   = r_res;
  assign res_idx    = r_row;

endmodule
`default_nettype wire

// File: tb/tb_aim_layer_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_aim_layer_sched
// Purpose  : Self-checking bench for aim_layer_sched with a behavioural
//            weight ROM, a neuron core model and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aim_layer_sched;

  localparam int NN       = 4;
  localparam int IW       = 2;
  localparam int TMO      = 64;
  localparam int CORE_LAT = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [71:0]   act_in = '0;
  logic          busy, layer_done, err, wrom_rd, core_start, res_valid;
  logic [IW-1:0] wrom_addr, res_idx;
  logic [15:0]   wrom_data = '0;
  logic [71:0]   core_act;
  logic [15:0]   core_wt;
  logic          core_done = 1'b0;
  logic [11:0]   core_result = '0;
  logic          res_ready = 1'b1;
  logic [11:0]   res_data;

  always #5 clk = ~clk;

  aim_layer_sched #(
    .NUM_NEURONS  (NN),
    .IDX_W        (IW),
    .CORE_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .act_in      (act_in),
    .busy        (busy),
    .layer_done  (layer_done),
    .err         (err),
    .wrom_addr   (wrom_addr),
    .wrom_rd     (wrom_rd),
    .wrom_data   (wrom_data),
    .core_start  (core_start),
    .core_act    (core_act),
    .core_wt     (core_wt),
    .core_done   (core_done),
    .core_result (core_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_idx     (res_idx)
  );

  // ---------------------------------------------------------------- models
  logic [15:0] rom [NN];
  logic        core_hang = 1'b0;
  int          core_cnt = 0;
  logic [11:0] core_pend = '0;

  function automatic logic [11:0] model_sum(input logic [15:0] w, input logic [71:0] a);
    int s;
    int wi;
    int ai;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      wi = int'($signed(w[2*i +: 2]));
      ai = int'($signed(a[9*i +: 9]));
      s += wi * ai;
    end
    return 12'(s);
  endfunction

  function automatic logic [11:0] exp_res(input logic [15:0] w, input logic [71:0] a);
    logic [11:0] v;
    v = model_sum(w, a);
`ifdef AIM_SCHED_RELU_EN
    if (v[11]) v = '0;
`endif
    return v;
  endfunction

  // Synchronous ROM: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (wrom_rd) wrom_data <= rom[wrom_addr];
  end

  // Core model: done pulse CORE_LAT cycles after core_start.
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_start && !core_hang) begin
      core_cnt  <= CORE_LAT - 1;
      core_pend <= model_sum(core_wt, core_act);
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_done   <= 1'b1;
        core_result <= core_pend;
      end
    end
  end

  // ------------------------------------------------------------ scoreboard
  typedef struct packed {
    logic [IW-1:0] idx;
    logic [11:0]   data;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   n_cstart = 0;
  int   n_done = 0;
  int   n_rd = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (core_start) n_cstart++;
      if (layer_done) n_done++;
      if (wrom_rd) n_rd++;
      if (res_valid && res_ready) begin
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got idx=%0d data=%0d, required no result", res_idx, $signed(res_data));
        end else begin
          e = sbq.pop_front();
          if ({res_idx, res_data} !== {e.idx, e.data}) begin
            errors++;
            $display("FAIL sb_result got idx=%0d data=%0d, required idx=%0d data=%0d",
                     res_idx, $signed(res_data), e.idx, $signed(e.data));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required finish");
    $fatal(1);
  end

  // ------------------------------------------------------------- utilities
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [71:0] a);
    act_in = a;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic push_layer(input logic [71:0] a);
    for (int r = 0; r < NN; r++) sbq.push_back('{idx: IW'(r), data: exp_res(rom[r], a)});
  endtask

  task automatic clear_counts();
    n_cstart = 0;
    n_done   = 0;
    n_rd     = 0;
  endtask

  task automatic wait_valid(input int maxc, output int cyc);
    cyc = 0;
    while (!res_valid && cyc < maxc) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (layer_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic load_basic_rom();
    rom[0] = 16'h5555;
    rom[1] = 16'hFFFF;
    rom[2] = 16'h0000;
    rom[3] = 16'h0001;
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b1;
    act_in = {8{9'h0AB}};
    tick();
    tick();
    checks++;
    if ({busy, layer_done, err, wrom_rd, core_start, res_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b, required 000000",
               {busy, layer_done, err, wrom_rd, core_start, res_valid});
    end
    checks++;
    if ({wrom_addr, core_act, core_wt, res_data, res_idx} !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%0d act=%h wt=%h data=%h idx=%0d, required all 0",
               wrom_addr, core_act, core_wt, res_data, res_idx);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, core_act} !== {1'b0, 72'h0}) begin
      errors++;
      $display("FAIL reset_start_ignored got busy=%b act=%h, required busy=0 act=0", busy, core_act);
    end
  endtask

  task automatic test_basic();
    logic [71:0] a;
    int cyc;
    bit ok;
    a = {8{9'd1}};
    load_basic_rom();
    res_ready = 1'b1;
    clear_counts();
    push_layer(a);
    checks++;
    if ({sbq[0].data, sbq[3].data} !== {exp_res(16'h5555, a), 12'd1}) begin
      errors++;
      $display("FAIL basic_model got %0d/%0d, required 8/1", $signed(sbq[0].data), $signed(sbq[3].data));
    end
    pulse_start(a);
    checks++;
    if ({busy, wrom_rd, wrom_addr} !== {1'b1, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL basic_fetch got busy=%b rd=%b addr=%0d, required 1 1 0", busy, wrom_rd, wrom_addr);
    end
    wait_valid(200, cyc);
    checks++;
    if (cyc + 1 !== 4 + CORE_LAT) begin
      errors++;
      $display("FAIL basic_latency got %0d, required %0d", cyc + 1, 4 + CORE_LAT);
    end
    wait_done(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_layer_done got timeout, required pulse");
    end
    tick();
    tick();
    checks++;
    if ({n_done, n_cstart, n_rd} !== {32'd1, 32'd3, 32'd4}) begin
      errors++;
      $display("FAIL basic_counts got done=%0d cstart=%0d rd=%0d, required 1 3 4", n_done, n_cstart, n_rd);
    end
    checks++;
    if ({err, busy, sbq.size()} !== {1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL basic_end got err=%b busy=%b left=%0d, required 0 0 0", err, busy, sbq.size());
    end
  endtask

  task automatic test_zero_skip();
    logic [71:0] a;
    int cyc;
    int v;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(200, 0)) - 100;
      a[9*i +: 9] = v[8:0];
    end
    rom[0] = 16'h0000;
    rom[1] = 16'h5555;
    rom[2] = 16'h0000;
    rom[3] = 16'hAAAA;
    res_ready = 1'b1;
    clear_counts();
    push_layer(a);
    pulse_start(a);
    wait_valid(200, cyc);
    checks++;
    if (cyc + 1 !== 3) begin
      errors++;
      $display("FAIL zero_latency got %0d, required 3", cyc + 1);
    end
    wait_done(400, ok);
    tick();
    tick();
    checks++;
    if ({ok, n_cstart, sbq.size()} !== {1'b1, 32'd2, 32'd0}) begin
      errors++;
      $display("FAIL zero_counts got ok=%b cstart=%0d left=%0d, required 1 2 0", ok, n_cstart, sbq.size());
    end
  endtask

  task automatic test_backpressure();
    logic [71:0] a;
    logic [11:0] d1;
    int cyc;
    bit ok;
    a  = {8{9'd1}};
    d1 = exp_res(16'hFFFF, a);
    load_basic_rom();
    res_ready = 1'b0;
    push_layer(a);
    pulse_start(a);
    wait_valid(200, cyc);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    wait_valid(200, cyc);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({res_valid, res_idx, res_data, wrom_rd} !== {1'b1, 2'd1, d1, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold got v=%b idx=%0d data=%0d rd=%b, required 1 1 %0d 0",
                 res_valid, res_idx, $signed(res_data), wrom_rd, $signed(d1));
      end
      tick();
    end
    res_ready = 1'b1;
    wait_done(400, ok);
    tick();
    checks++;
    if ({ok, sbq.size()} !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL bp_end got ok=%b left=%0d, required 1 0", ok, sbq.size());
    end
  endtask

  task automatic test_timeout();
    logic [71:0] a;
    int cyc;
    bit ok;
    a = {8{9'd1}};
    rom[0] = 16'h5555;
    rom[1] = 16'h0000;
    rom[2] = 16'h0000;
    rom[3] = 16'h0000;
    core_hang = 1'b1;
    res_ready = 1'b1;
    for (int r = 0; r < NN; r++) sbq.push_back('{idx: IW'(r), data: 12'd0});
    pulse_start(a);
    cyc = 0;
    while (!core_start && cyc < 20) begin
      tick();
      cyc++;
    end
    wait_valid(200, cyc);
    checks++;
    if (cyc !== TMO) begin
      errors++;
      $display("FAIL tmo_latency got %0d, required %0d", cyc, TMO);
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_err got %b, required 1", err);
    end
    wait_done(400, ok);
    tick();
    tick();
    checks++;
    if ({ok, err, busy, sbq.size()} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL tmo_end got ok=%b err=%b busy=%b left=%0d, required 1 1 0 0", ok, err, busy, sbq.size());
    end
    core_hang = 1'b0;
    load_basic_rom();
    push_layer(a);
    pulse_start(a);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_err_clear got %b, required 0", err);
    end
    wait_done(400, ok);
    tick();
    checks++;
    if ({ok, sbq.size()} !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL tmo_relayer got ok=%b left=%0d, required 1 0", ok, sbq.size());
    end
  endtask

  task automatic test_start_ignored();
    logic [71:0] a;
    int cyc;
    bit ok;
    a = {8{9'd1}};
    load_basic_rom();
    res_ready = 1'b1;
    clear_counts();
    push_layer(a);
    pulse_start(a);
    cyc = 0;
    while (!core_start && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    tick();
    pulse_start({8{9'd3}});
    checks++;
    if (core_act !== a) begin
      errors++;
      $display("FAIL ign_act got %h, required %h", core_act, a);
    end
    wait_done(400, ok);
    repeat (5) tick();
    checks++;
    if ({ok, n_done, busy, sbq.size()} !== {1'b1, 32'd1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL ign_end got ok=%b done=%0d busy=%b left=%0d, required 1 1 0 0",
               ok, n_done, busy, sbq.size());
    end
  endtask

  task automatic test_reset_emit();
    logic [71:0] a;
    int cyc;
    int seen;
    a = {8{9'd1}};
    load_basic_rom();
    res_ready = 1'b0;
    sbq.push_back('{idx: 2'd0, data: exp_res(rom[0], a)});
    sbq.push_back('{idx: 2'd1, data: exp_res(rom[1], a)});
    pulse_start(a);
    for (int k = 0; k < 2; k++) begin
      wait_valid(200, cyc);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
    wait_valid(200, cyc);
    checks++;
    if ({res_valid, res_idx} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL rst_emit_pre got v=%b idx=%0d, required 1 2", res_valid, res_idx);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({res_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_emit_valid got v=%b busy=%b, required 0 0", res_valid, busy);
    end
    rst_n     = 1'b1;
    res_ready = 1'b1;
    clear_counts();
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      if (res_valid) seen++;
      tick();
    end
    checks++;
    if ({seen, n_done, sbq.size()} !== {32'd0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL rst_emit_after got results=%0d done=%0d left=%0d, required 0 0 0",
               seen, n_done, sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_skip();
    test_backpressure();
    test_timeout();
    test_start_ignored();
    test_reset_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
